perceptron: RTL and testbench

PERCEPTRON -- requirements
Module: perceptron

---
 rtl/common_pkg.sv | 11 +
 rtl/perceptron.sv | 117 +++++++++++
 tb/tb_perceptron.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared types for the neural-network building blocks.
package common_pkg;

  typedef enum logic [1:0] {
    SIGMOID = 2'd0,
    RELU    = 2'd1,
    TANH    = 2'd2,
    LINEAR  = 2'd3
  } act_func;

endpackage : common_pkg

// File: rtl/perceptron.sv
// Single trainable neuron: weighted sum, selectable activation, and on-line
// SGD weight/bias update driven by gradients fed back from the next layer.
module perceptron
  import common_pkg::*;
#(
  parameter int unsigned input_units  = 2,
  parameter int unsigned output_units = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  real     values                    [input_units],
  input  act_func activation,
  input  logic    training,
  input  real     learning_rate,
  input  real     next_layer_weights        [output_units],
  input  real     error_gradient_next_layer [output_units],
  output real     prediction,
  output real     error_gradient,
  output real     current_weights           [input_units]
);

  localparam real W_INIT = 0.1;

  real w_q  [input_units];
  real w_d  [input_units];
  real xr_q [input_units];
  real b_q, b_d;
  real zr_q;
  real z_d;
  real pred_q, pred_d;
  real deriv;
  real grad_sum;

  // Pre-activation from pre-edge weights and the incoming values
  always_comb begin
    z_d = b_q;
    for (int unsigned i = 0; i < input_units; i++) begin
      z_d = z_d + w_q[i] * values[i];
    end
  end

  // Activation of the new pre-activation; unknown encodings fall back to linear
  always_comb begin
    pred_d = z_d;
    case (activation)
      SIGMOID: pred_d = 1.0 / (1.0 + $exp(-z_d));
      RELU:    pred_d = (z_d > 0.0) ? z_d : 0.0;
      TANH:    pred_d = $tanh(z_d);
      LINEAR:  pred_d = z_d;
      default: pred_d = z_d;
    endcase
  end

  // Derivative evaluated on the registered prediction / pre-activation
  always_comb begin
    deriv = 1.0;
    case (activation)
      SIGMOID: deriv = pred_q * (1.0 - pred_q);
      RELU:    deriv = (zr_q > 0.0) ? 1.0 : 0.0;
      TANH:    deriv = 1.0 - pred_q * pred_q;
      LINEAR:  deriv = 1.0;
      default: deriv = 1.0;
    endcase
  end

  always_comb begin
    grad_sum = 0.0;
    for (int unsigned k = 0; k < output_units; k++) begin
      grad_sum = grad_sum + next_layer_weights[k] * error_gradient_next_layer[k];
    end
  end

  assign error_gradient = grad_sum * deriv;

  // SGD step uses the latched inputs that produced the current gradient
  always_comb begin
    b_d = b_q;
    for (int unsigned i = 0; i < input_units; i++) begin
      w_d[i] = w_q[i];
    end
    if (training) begin
      b_d = b_q - learning_rate * error_gradient;
      for (int unsigned i = 0; i < input_units; i++) begin
        w_d[i] = w_q[i] - learning_rate * error_gradient * xr_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < input_units; i++) begin
        w_q[i]  <= W_INIT;
        xr_q[i] <= 0.0;
      end
      b_q    <= 0.0;
      zr_q   <= 0.0;
      pred_q <= 0.0;
    end else begin
      for (int unsigned i = 0; i < input_units; i++) begin
        w_q[i]  <= w_d[i];
        xr_q[i] <= values[i];
      end
      b_q    <= b_d;
      zr_q   <= z_d;
      pred_q <= pred_d;
    end
  end

  assign prediction = pred_q;

  always_comb begin
    for (int unsigned i = 0; i < input_units; i++) begin
      current_weights[i] = w_q[i];
    end
  end

endmodule : perceptron

// File: tb/tb_perceptron.sv
// Directed bench for the perceptron: reset, inference per activation,
// a single linear update, ReLU gating, AND learning and async reset.
module tb_perceptron;
  import common_pkg::*;

  localparam real TOL = 1.0e-5;

  logic    clk;
  logic    rst;
  real     values                    [2];
  act_func activation;
  logic    training;
  real     learning_rate;
  real     next_layer_weights        [1];
  real     error_gradient_next_layer [1];
  real     prediction;
  real     error_gradient;
  real     current_weights           [2];

  int n_checks;
  int n_pass;

  perceptron #(.input_units(2), .output_units(1)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .values                    (values),
    .activation                (activation),
    .training                  (training),
    .learning_rate             (learning_rate),
    .next_layer_weights        (next_layer_weights),
    .error_gradient_next_layer (error_gradient_next_layer),
    .prediction                (prediction),
    .error_gradient            (error_gradient),
    .current_weights           (current_weights)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input real obs, input real exp_v);
    n_checks++;
    assert (((obs - exp_v) < TOL) && ((exp_v - obs) < TOL)) n_pass++;
    else $error("FAIL %s observed=%f expected=%f", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    real a, y_lat, den;
    real cls;
    logic [1:0] pat;
    n_checks = 0;
    n_pass   = 0;

    rst = 1'b0;
    values[0] = 0.0; values[1] = 0.0;
    activation = SIGMOID;
    training = 1'b0;
    learning_rate = 1.0;
    next_layer_weights[0] = 1.0;
    error_gradient_next_layer[0] = 1.0;
    #12;
    chk("reset_w0", current_weights[0], 0.1);
    chk("reset_w1", current_weights[1], 0.1);
    chk("reset_pred", prediction, 0.0);
    chk("reset_grad_sigmoid", error_gradient, 0.0);

    // Sigmoid inference
    rst = 1'b1;
    values[0] = 1.0; values[1] = 1.0;
    tick(); tick();
    chk("sig_pred", prediction, 0.549834);
    chk("sig_w0", current_weights[0], 0.1);
    chk("sig_w1", current_weights[1], 0.1);
    chk("sig_grad", error_gradient, 0.247517);

    // Tanh inference and derivative
    activation = TANH;
    next_layer_weights[0] = 2.0;
    error_gradient_next_layer[0] = 0.5;
    tick(); tick();
    chk("tanh_pred", prediction, 0.197375);
    chk("tanh_grad", error_gradient, 0.961043);

    // Linear single update
    pulse_reset();
    activation = LINEAR;
    next_layer_weights[0] = 1.0;
    error_gradient_next_layer[0] = 1.0;
    values[0] = 1.0; values[1] = 0.0;
    training = 1'b0;
    tick();
    chk("lin_edge1_pred", prediction, 0.1);
    training = 1'b1;
    tick();
    chk("lin_edge2_w0", current_weights[0], -0.9);
    chk("lin_edge2_w1", current_weights[1], 0.1);
    training = 1'b0;
    tick();
    chk("lin_edge3_pred", prediction, -1.9);

    // ReLU gating blocks learning
    pulse_reset();
    activation = RELU;
    values[0] = -5.0; values[1] = -5.0;
    training = 1'b1;
    tick(); tick();
    chk("relu_pred", prediction, 0.0);
    chk("relu_grad", error_gradient, 0.0);
    chk("relu_w0", current_weights[0], 0.1);
    chk("relu_w1", current_weights[1], 0.1);

    // AND learning with BCE gradient fed back
    pulse_reset();
    activation = SIGMOID;
    learning_rate = 1.0;
    next_layer_weights[0] = 1.0;
    error_gradient_next_layer[0] = 0.0;
    training = 1'b1;
    for (int ep = 0; ep < 100; ep++) begin
      for (int p = 0; p < 4; p++) begin
        pat = 2'(p);
        values[0] = pat[1] ? 1.0 : 0.0;
        values[1] = pat[0] ? 1.0 : 0.0;
        y_lat = (pat == 2'b11) ? 1.0 : 0.0;
        for (int h = 0; h < 2; h++) begin
          tick();
          a = prediction;
          den = a * (1.0 - a);
          if (den < 1.0e-12) den = 1.0e-12;
          error_gradient_next_layer[0] = (a - y_lat) / den;
        end
      end
    end
    training = 1'b0;
    for (int p = 0; p < 4; p++) begin
      pat = 2'(p);
      values[0] = pat[1] ? 1.0 : 0.0;
      values[1] = pat[0] ? 1.0 : 0.0;
      tick(); tick();
      cls = (prediction > 0.5) ? 1.0 : 0.0;
      chk($sformatf("and_class_%0d", p), cls, (pat == 2'b11) ? 1.0 : 0.0);
    end

    // Asynchronous reset mid-cycle while training
    training = 1'b1;
    values[0] = 1.0; values[1] = 1.0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("async_w0", current_weights[0], 0.1);
    chk("async_w1", current_weights[1], 0.1);
    chk("async_pred", prediction, 0.0);
    rst = 1'b1;
    training = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_perceptron
